mem_access_guard: RTL and testbench
===================================

MEM_ACCESS_GUARD -- requirements
Module: mem_access_guard

Interface
REQ-001 SHALL take parameter N_CH, default 2: number of independent request channels.
REQ-002 SHALL take parameter N_ENDPOINTS, default 4: number of endpoint table entries.
REQ-003 SHALL take parameter VADDR_BITS, default 48, and LEN_BITS, default 28: request address and length widths.
REQ-004 SHALL take parameter TAG_BITS, default 16: opaque per-request payload, forwarded unchanged.
REQ-005 SHALL take parameter LOG_DEPTH, default 8 (power of 2): violation log FIFO depth.
REQ-006 SHALL take parameter FAIL_STOP, default 0: 1 = a channel halts after its first violation.
REQ-007 aclk  in  1  sole clock; all logic on rising edge.
REQ-008 areset  in  1  reset, synchronous, active-high.
REQ-009 cfg_we, cfg_idx[$clog2(N_ENDPOINTS)], cfg_valid, cfg_rights[2], cfg_base[VADDR_BITS], cfg_bound[VADDR_BITS]  in: endpoint write port; rights bit0 = read, bit1 = write.
REQ-010 s_valid[N_CH], s_dir[N_CH], s_vaddr[N_CH*VADDR_BITS], s_len[N_CH*LEN_BITS], s_tag[N_CH*TAG_BITS]  in; s_ready[N_CH]  out: request input; dir 0 = read, 1 = write.
REQ-011 m_valid[N_CH], m_dir, m_vaddr, m_len, m_tag  out (same widths); m_ready[N_CH]  in: authorized request output.
REQ-012 viol_clear  in  1: clears halted channels and the sticky irq.
REQ-013 log_valid, log_ch[$clog2(N_CH)], log_dir, log_vaddr, log_len  out; log_ready  in: violation log FIFO read port.
REQ-014 irq  out  1: sticky violation flag. viol_count[32], log_lost[32]  out: counters.

Function
REQ-015 Channels SHALL be independent; each has a one-entry registered check stage (latency exactly 1 cycle, s to m).
REQ-016 s_ready[c] SHALL be 1 when stage c is empty, or holds an authorized entry with m_ready[c]=1, or holds a denied entry, and channel c is not halted; full throughput is 1 request/cycle/channel.
REQ-017 The check SHALL grant iff len>0 and some entry i has valid, rights[dir], base<=bound, vaddr>=base, len<=bound-base+1, and vaddr<=bound-len+1, all computed at VADDR_BITS+1 width with no wrap.
REQ-018 Granted entries SHALL drive m_valid and hold m_* stable until m_ready; denied entries SHALL never assert m_valid and SHALL leave the stage the cycle after capture.
REQ-019 A cfg write SHALL update entry cfg_idx at the clock edge; requests captured on that same edge use the old table; cfg_idx>=N_ENDPOINTS is ignored.
REQ-020 Each denied capture SHALL increment viol_count (saturating at 2^32-1) and set irq.
REQ-021 The denied request SHALL be pushed to the log FIFO; with several denials in one cycle the lowest channel is logged and each other denial increments log_lost; a push while the FIFO is full is dropped and increments log_lost (saturating).
REQ-022 The log SHALL be first-word-fall-through; pop on log_valid&&log_ready; push and pop in one cycle while full SHALL both succeed.
REQ-023 With FAIL_STOP=1, a channel SHALL deassert s_ready from the cycle after its denial until viol_clear; any authorized entry already in the stage still drains.
REQ-024 viol_clear SHALL clear irq and halt states; a denial on the same edge wins (irq stays 1). Counters SHALL be cleared only by reset.

Reset
REQ-025 While areset=1: table entries invalid, stages empty, m_valid=0, s_ready=0, log empty (log_valid=0), irq=0, viol_count=0, log_lost=0, halts cleared; s_ready rises the cycle after release.
REQ-026 Reset asserted mid-transfer SHALL discard in-flight stage contents without emitting them.

Verification
REQ-027 Entry0 base=0x1000, bound=0x1FFF, rights=11; ch0 read vaddr=0x1F00 len=0x100 -> m_valid[0] 1 cycle later; len=0x101 -> dropped, viol_count=1, log holds {ch0, rd, 0x1F00, 0x101}.
REQ-028 Entry bound=2^48-1, vaddr=2^48-16, len=32 -> denied (no wrap); len=0 -> denied.
REQ-029 Rights=01, write request inside range -> denied, irq=1; viol_clear -> irq=0.
REQ-030 Ch0 and ch1 denied same cycle with log holding 7 entries -> ch0 logged (FIFO full), log_lost=1; next denial -> log_lost=2.
REQ-031 FAIL_STOP=1: denial on ch1 -> s_ready[1]=0 while ch0 still streams 1/cycle; viol_clear -> s_ready[1]=1 next cycle.
REQ-032 m_ready[0]=0 for 5 cycles with granted entry -> m_* stable, s_ready[0]=0; areset mid-stall -> m_valid=0 next cycle.

Source files
------------

// File: rtl/mem_access_guard.sv
// Per-channel access checker: each request is matched against an endpoint rights/range table.
// Granted requests are forwarded, and denied requests are counted and logged to a FWFT FIFO.
module mem_access_guard #(
  parameter int N_CH        = 2,
  parameter int N_ENDPOINTS = 4,
  parameter int VADDR_BITS  = 48,
  parameter int LEN_BITS    = 28,
  parameter int TAG_BITS    = 16,
  parameter int LOG_DEPTH   = 8,
  parameter int FAIL_STOP   = 0,
  localparam int IDX_W      = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic                         cfg_valid,
  input  logic [1:0]                   cfg_rights,
  input  logic [VADDR_BITS-1:0]        cfg_base,
  input  logic [VADDR_BITS-1:0]        cfg_bound,
  input  logic [N_CH-1:0]              s_valid,
  input  logic [N_CH-1:0]              s_dir,
  input  logic [N_CH*VADDR_BITS-1:0]   s_vaddr,
  input  logic [N_CH*LEN_BITS-1:0]     s_len,
  input  logic [N_CH*TAG_BITS-1:0]     s_tag,
  output logic [N_CH-1:0]              s_ready,
  output logic [N_CH-1:0]              m_valid,
  output logic [N_CH-1:0]              m_dir,
  output logic [N_CH*VADDR_BITS-1:0]   m_vaddr,
  output logic [N_CH*LEN_BITS-1:0]     m_len,
  output logic [N_CH*TAG_BITS-1:0]     m_tag,
  input  logic [N_CH-1:0]              m_ready,
  input  logic                         viol_clear,
  output logic                         log_valid,
  output logic [CH_W-1:0]              log_ch,
  output logic                         log_dir,
  output logic [VADDR_BITS-1:0]        log_vaddr,
  output logic [LEN_BITS-1:0]          log_len,
  input  logic                         log_ready,
  output logic                         irq,
  output logic [31:0]                  viol_count,
  output logic [31:0]                  log_lost
);

  // One extra bit so that bound+1 and bound-len+1 never wrap.
  localparam int CW = ((LEN_BITS > VADDR_BITS) ? LEN_BITS : VADDR_BITS) + 1;
  localparam int AW = $clog2(LOG_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic                  dir;
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
  } log_entry_t;

  logic [N_ENDPOINTS-1:0] ep_valid;
  logic [1:0]             ep_rights [N_ENDPOINTS];
  logic [VADDR_BITS-1:0]  ep_base   [N_ENDPOINTS];
  logic [VADDR_BITS-1:0]  ep_bound  [N_ENDPOINTS];

  logic                   live;
  logic [N_CH-1:0]        halted;
  logic [N_CH-1:0]        st_valid;
  logic [N_CH-1:0]        st_grant;
  logic [N_CH-1:0]        grant;
  logic [N_CH-1:0]        accept;
  logic [N_CH-1:0]        deny;
  logic [32:0]            n_deny;
  logic [32:0]            lost_inc;
  logic [32:0]            viol_sum;
  logic [32:0]            lost_sum;
  logic [CH_W-1:0]        log_sel;
  logic                   cfg_hit;

  log_entry_t             log_mem [LOG_DEPTH];
  log_entry_t             push_entry;
  log_entry_t             head;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   fifo_full;
  logic                   pop;
  logic                   push_req;
  logic                   push_ok;

  assign cfg_hit = cfg_we && (int'(cfg_idx) < N_ENDPOINTS);

  always_ff @(posedge aclk) begin
    if (areset) begin
      ep_valid <= '0;
    end else if (cfg_hit) begin
      ep_valid[cfg_idx] <= cfg_valid;
    end
  end

  // NOTE: pure data storage qualified by a reset valid bit needs no reset of its own.
  always_ff @(posedge aclk) begin
    if (cfg_hit) begin
      ep_rights[cfg_idx] <= cfg_rights;
      ep_base[cfg_idx]   <= cfg_base;
      ep_bound[cfg_idx]  <= cfg_bound;
    end
  end

  // NOTE: combinational blocks use blocking assignments and default every output first to avoid latches.
  always_comb begin
    logic [CW-1:0] va, ln, b, e;
    grant = '0;
    va    = '0;
    ln    = '0;
    b     = '0;
    e     = '0;
    for (int c = 0; c < N_CH; c++) begin
      va = CW'(s_vaddr[c*VADDR_BITS +: VADDR_BITS]);
      ln = CW'(s_len[c*LEN_BITS +: LEN_BITS]);
      for (int i = 0; i < N_ENDPOINTS; i++) begin
        b = CW'(ep_base[i]);
        e = CW'(ep_bound[i]);
        if (ep_valid[i] && ep_rights[i][s_dir[c]] && (ln != '0) && (b <= e) &&
            (va >= b) && (ln <= e - b + ONE) && (va <= e - ln + ONE)) begin
          grant[c] = 1'b1;
        end
      end
    end
  end

  assign s_ready = {N_CH{live & ~areset}} & ~halted & (~st_valid | ~st_grant | m_ready);
  assign accept  = s_valid & s_ready;
  assign deny    = accept & ~grant;
  assign m_valid = st_valid & st_grant;

  always_ff @(posedge aclk) begin
    if (areset) begin
      live     <= 1'b0;
      st_valid <= '0;
      halted   <= '0;
    end else begin
      live <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if (accept[c]) begin
          st_valid[c] <= 1'b1;
        end else if (st_valid[c] && (!st_grant[c] || m_ready[c])) begin
          st_valid[c] <= 1'b0;
        end
        if ((FAIL_STOP != 0) && deny[c]) begin
          halted[c] <= 1'b1;
        end else if (viol_clear) begin
          halted[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (accept[c]) begin
        st_grant[c]                          <= grant[c];
        m_dir[c]                             <= s_dir[c];
        m_vaddr[c*VADDR_BITS +: VADDR_BITS]  <= s_vaddr[c*VADDR_BITS +: VADDR_BITS];
        m_len[c*LEN_BITS +: LEN_BITS]        <= s_len[c*LEN_BITS +: LEN_BITS];
        m_tag[c*TAG_BITS +: TAG_BITS]        <= s_tag[c*TAG_BITS +: TAG_BITS];
      end
    end
  end

  // The lowest denying channel wins the single log slot for this cycle.
  always_comb begin
    n_deny  = '0;
    log_sel = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (deny[c]) begin
        n_deny  = n_deny + 33'd1;
        log_sel = CH_W'(c);
      end
    end
  end

  assign push_entry = '{ch:    log_sel,
                        dir:   s_dir[log_sel],
                        vaddr: s_vaddr[int'(log_sel)*VADDR_BITS +: VADDR_BITS],
                        len:   s_len[int'(log_sel)*LEN_BITS +: LEN_BITS]};

  assign fifo_full = (wr_ptr - rd_ptr) == PW'(LOG_DEPTH);
  assign log_valid = (wr_ptr != rd_ptr);
  assign pop       = log_valid && log_ready;
  assign push_req  = |deny;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign lost_inc  = n_deny - {32'd0, push_ok};
  assign viol_sum  = {1'b0, viol_count} + n_deny;
  assign lost_sum  = {1'b0, log_lost} + lost_inc;

  assign head      = log_mem[rd_ptr[AW-1:0]];
  assign log_ch    = head.ch;
  assign log_dir   = head.dir;
  assign log_vaddr = head.vaddr;
  assign log_len   = head.len;

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      log_mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      irq        <= 1'b0;
      viol_count <= '0;
      log_lost   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_req) begin
        irq <= 1'b1;
      end else if (viol_clear) begin
        irq <= 1'b0;
      end
      viol_count <= viol_sum[32] ? '1 : viol_sum[31:0];
      log_lost   <= lost_sum[32] ? '1 : lost_sum[31:0];
    end
  end

endmodule

// File: tb/tb_mem_access_guard.sv
// Scoreboard bench for mem_access_guard: a reference grant model predicts forwarded requests,
// log entries and counters; a FAIL_STOP=1 instance sharing the inputs covers channel halting.
module tb_mem_access_guard;

  localparam int VW = 48;
  localparam int LW = 28;
  localparam int TW = 16;

  logic         aclk = 1'b0;
  logic         areset;
  logic         cfg_we, cfg_valid;
  logic [1:0]   cfg_idx, cfg_rights;
  logic [VW-1:0] cfg_base, cfg_bound;
  logic [1:0]   s_valid, s_dir, m_ready;
  logic [2*VW-1:0] s_vaddr;
  logic [2*LW-1:0] s_len;
  logic [2*TW-1:0] s_tag;
  logic         viol_clear, log_ready;

  logic [1:0]   s_ready, m_valid, m_dir;
  logic [2*VW-1:0] m_vaddr;
  logic [2*LW-1:0] m_len;
  logic [2*TW-1:0] m_tag;
  logic         log_valid, log_ch, log_dir, irq;
  logic [VW-1:0] log_vaddr;
  logic [LW-1:0] log_len;
  logic [31:0]  viol_count, log_lost;

  logic [1:0]   fs_s_ready, fs_m_valid, fs_m_dir;
  logic [2*VW-1:0] fs_m_vaddr;
  logic [2*LW-1:0] fs_m_len;
  logic [2*TW-1:0] fs_m_tag;
  logic         fs_log_valid, fs_log_ch, fs_log_dir, fs_irq;
  logic [VW-1:0] fs_log_vaddr;
  logic [LW-1:0] fs_log_len;
  logic [31:0]  fs_viol_count, fs_log_lost;

  always #5 aclk = ~aclk;

  mem_access_guard dut (
    .aclk(aclk), .areset(areset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_rights(cfg_rights),
    .cfg_base(cfg_base), .cfg_bound(cfg_bound),
    .s_valid(s_valid), .s_dir(s_dir), .s_vaddr(s_vaddr), .s_len(s_len), .s_tag(s_tag),
    .s_ready(s_ready),
    .m_valid(m_valid), .m_dir(m_dir), .m_vaddr(m_vaddr), .m_len(m_len), .m_tag(m_tag),
    .m_ready(m_ready), .viol_clear(viol_clear),
    .log_valid(log_valid), .log_ch(log_ch), .log_dir(log_dir), .log_vaddr(log_vaddr),
    .log_len(log_len), .log_ready(log_ready),
    .irq(irq), .viol_count(viol_count), .log_lost(log_lost)
  );

  mem_access_guard #(.FAIL_STOP(1)) dut_fs (
    .aclk(aclk), .areset(areset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_rights(cfg_rights),
    .cfg_base(cfg_base), .cfg_bound(cfg_bound),
    .s_valid(s_valid), .s_dir(s_dir), .s_vaddr(s_vaddr), .s_len(s_len), .s_tag(s_tag),
    .s_ready(fs_s_ready),
    .m_valid(fs_m_valid), .m_dir(fs_m_dir), .m_vaddr(fs_m_vaddr), .m_len(fs_m_len),
    .m_tag(fs_m_tag), .m_ready(m_ready), .viol_clear(viol_clear),
    .log_valid(fs_log_valid), .log_ch(fs_log_ch), .log_dir(fs_log_dir),
    .log_vaddr(fs_log_vaddr), .log_len(fs_log_len), .log_ready(log_ready),
    .irq(fs_irq), .viol_count(fs_viol_count), .log_lost(fs_log_lost)
  );

  typedef struct packed {
    logic          dir;
    logic [VW-1:0] va;
    logic [LW-1:0] len;
    logic [TW-1:0] tag;
  } m_exp_t;

  typedef struct packed {
    logic          ch;
    logic          dir;
    logic [VW-1:0] va;
    logic [LW-1:0] len;
  } log_exp_t;

  m_exp_t   q0[$];
  m_exp_t   q1[$];
  log_exp_t lq[$];

  bit            t_valid  [4];
  logic [1:0]    t_rights [4];
  logic [VW-1:0] t_base   [4];
  logic [VW-1:0] t_bound  [4];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_viol, exp_lost;
  bit          exp_irq, exp_rdy_en;
  logic [1:0]  acc;

  function automatic int q_size(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic m_exp_t q_front(input int c);
    return (c == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(input int c);
    if (c == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void q_push(input int c, input m_exp_t e);
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Reference check written as an end-address comparison in 64-bit arithmetic.
  function automatic bit model_grant(input bit d, input logic [VW-1:0] va, input logic [LW-1:0] ln);
    longint unsigned a, l, b, e;
    a = 64'(va);
    l = 64'(ln);
    for (int i = 0; i < 4; i++) begin
      b = 64'(t_base[i]);
      e = 64'(t_bound[i]);
      if (t_valid[i] && t_rights[i][d] && l != 0 && b <= e && a >= b && a + l <= e + 1)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_clear();
    q0.delete();
    q1.delete();
    lq.delete();
    for (int i = 0; i < 4; i++) t_valid[i] = 1'b0;
    exp_viol = '0;
    exp_lost = '0;
    exp_irq  = 1'b0;
  endfunction

  // One clock: compare outputs at the falling edge, predict the rising-edge effects.
  task automatic step();
    m_exp_t   e, got;
    log_exp_t le, lg;
    bit       exp_rdy, first;
    @(negedge aclk);
    for (int c = 0; c < 2; c++) begin
      exp_rdy = !areset && exp_rdy_en && (q_size(c) == 0 || m_ready[c]);
      n_checks++;
      if (s_ready[c] !== exp_rdy) begin
        n_fail++;
        $display("FAIL s_ready[%0d]: got %b expected %b at %0t", c, s_ready[c], exp_rdy, $time);
      end
      n_checks++;
      if (m_valid[c] !== (q_size(c) != 0)) begin
        n_fail++;
        $display("FAIL m_valid[%0d]: got %b expected %b at %0t", c, m_valid[c], q_size(c) != 0, $time);
      end
      if (m_valid[c] === 1'b1 && q_size(c) != 0) begin
        e   = q_front(c);
        got = {m_dir[c], m_vaddr[c*VW +: VW], m_len[c*LW +: LW], m_tag[c*TW +: TW]};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL m_data[%0d]: got %h expected %h at %0t", c, got, e, $time);
        end
        if (m_ready[c]) q_pop(c);
      end
    end
    n_checks++;
    if (log_valid !== (lq.size() != 0)) begin
      n_fail++;
      $display("FAIL log_valid: got %b expected %b at %0t", log_valid, lq.size() != 0, $time);
    end
    if (log_valid === 1'b1 && lq.size() != 0) begin
      le = lq[0];
      lg = {log_ch, log_dir, log_vaddr, log_len};
      n_checks++;
      if (lg !== le) begin
        n_fail++;
        $display("FAIL log_entry: got %h expected %h at %0t", lg, le, $time);
      end
      if (log_ready) void'(lq.pop_front());
    end
    n_checks++;
    if (irq !== exp_irq || viol_count !== exp_viol || log_lost !== exp_lost) begin
      n_fail++;
      $display("FAIL status: got irq=%b viol=%0d lost=%0d expected irq=%b viol=%0d lost=%0d at %0t",
               irq, viol_count, log_lost, exp_irq, exp_viol, exp_lost, $time);
    end
    first = 1'b1;
    acc   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (s_valid[c] && s_ready[c]) begin
        acc[c] = 1'b1;
        e = {s_dir[c], s_vaddr[c*VW +: VW], s_len[c*LW +: LW], s_tag[c*TW +: TW]};
        if (model_grant(e.dir, e.va, e.len)) begin
          q_push(c, e);
        end else begin
          exp_viol++;
          if (first && lq.size() < 8) lq.push_back({c[0], e.dir, e.va, e.len});
          else                        exp_lost++;
          first = 1'b0;
        end
      end
    end
    if (!first)          exp_irq = 1'b1;
    else if (viol_clear) exp_irq = 1'b0;
    if (cfg_we && !areset) begin
      t_valid[cfg_idx]  = cfg_valid;
      t_rights[cfg_idx] = cfg_rights;
      t_base[cfg_idx]   = cfg_base;
      t_bound[cfg_idx]  = cfg_bound;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int c, input bit d, input logic [VW-1:0] va,
                         input logic [LW-1:0] ln, input logic [TW-1:0] tg);
    s_valid[c]         = 1'b1;
    s_dir[c]           = d;
    s_vaddr[c*VW +: VW] = va;
    s_len[c*LW +: LW]   = ln;
    s_tag[c*TW +: TW]   = tg;
  endtask

  task automatic cfg_write(input int idx, input bit v, input logic [1:0] r,
                           input logic [VW-1:0] b, input logic [VW-1:0] e);
    cfg_we     = 1'b1;
    cfg_idx    = idx[1:0];
    cfg_valid  = v;
    cfg_rights = r;
    cfg_base   = b;
    cfg_bound  = e;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    s_valid    = '0;
    cfg_we     = 1'b0;
    viol_clear = 1'b0;
    @(posedge aclk);
    #1;
    model_clear();
    exp_rdy_en = 1'b0;
    step();
    areset = 1'b0;
    step();
    exp_rdy_en = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    set_req(0, 1'b0, 48'h1000, 28'h10, 16'h1);
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (m_valid !== 2'b00)   begin n_fail++; $display("FAIL rst_m_valid: got %b expected 00", m_valid); end
    n_checks++; if (s_ready !== 2'b00)   begin n_fail++; $display("FAIL rst_s_ready: got %b expected 00", s_ready); end
    n_checks++; if (log_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_log_valid: got %b expected 0", log_valid); end
    n_checks++; if (irq !== 1'b0)        begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    n_checks++; if (viol_count !== 32'd0) begin n_fail++; $display("FAIL rst_viol_count: got %0d expected 0", viol_count); end
    n_checks++; if (log_lost !== 32'd0)  begin n_fail++; $display("FAIL rst_log_lost: got %0d expected 0", log_lost); end
    s_valid = '0;
    areset  = 1'b0;
    n_checks++; if (s_ready !== 2'b00)   begin n_fail++; $display("FAIL rel_s_ready_early: got %b expected 00", s_ready); end
    @(posedge aclk);
    #1;
    n_checks++; if (s_ready !== 2'b11)   begin n_fail++; $display("FAIL rel_s_ready: got %b expected 11", s_ready); end
    model_clear();
    exp_rdy_en = 1'b1;
  endtask

  task automatic test_grant();
    cfg_write(0, 1'b1, 2'b11, 48'h1000, 48'h1FFF);
    set_req(0, 1'b0, 48'h1F00, 28'h100, 16'h00A5);
    step();
    s_valid = '0;
    n_checks++;
    if (m_valid[0] !== 1'b1 || m_vaddr[47:0] !== 48'h1F00)
      begin n_fail++; $display("FAIL grant_latency: got v=%b va=%h expected v=1 va=1f00", m_valid[0], m_vaddr[47:0]); end
    step();
    set_req(0, 1'b0, 48'h1F00, 28'h101, 16'h00A6);
    step();
    s_valid = '0;
    n_checks++;
    if (m_valid[0] !== 1'b0 || viol_count !== 32'd1)
      begin n_fail++; $display("FAIL deny_basic: got v=%b viol=%0d expected v=0 viol=1", m_valid[0], viol_count); end
    n_checks++;
    if ({log_valid, log_ch, log_dir, log_vaddr, log_len} !== {1'b1, 1'b0, 1'b0, 48'h1F00, 28'h101})
      begin n_fail++; $display("FAIL deny_log: got v=%b ch=%b dir=%b va=%h len=%h", log_valid, log_ch, log_dir, log_vaddr, log_len); end
    step();
    set_req(0, 1'b1, 48'h1000, 28'h1000, 16'h0001); step();
    set_req(0, 1'b0, 48'h0FFF, 28'h1,    16'h0002); step();
    set_req(0, 1'b0, 48'h1FFF, 28'h1,    16'h0003); step();
    set_req(1, 1'b1, 48'h1FFF, 28'h2,    16'h0004); s_valid[0] = 1'b0; step();
    s_valid = '0;
    step();
  endtask

  task automatic test_wrap();
    cfg_write(1, 1'b1, 2'b11, 48'hFFFF_FFFF_FF00, 48'hFFFF_FFFF_FFFF);
    cfg_write(2, 1'b1, 2'b11, 48'h5000, 48'h4000);
    set_req(0, 1'b0, 48'hFFFF_FFFF_FFF0, 28'd32, 16'h0010); step();
    set_req(0, 1'b0, 48'hFFFF_FFFF_FFF0, 28'd0,  16'h0011); step();
    set_req(0, 1'b1, 48'hFFFF_FFFF_FFF0, 28'd16, 16'h0012); step();
    s_valid = '0;
    n_checks++;
    if (m_valid[0] !== 1'b1 || m_len[LW-1:0] !== 28'd16)
      begin n_fail++; $display("FAIL wrap_end_grant: got v=%b len=%0d expected v=1 len=16", m_valid[0], m_len[LW-1:0]); end
    set_req(1, 1'b0, 48'h4800, 28'd1, 16'h0013); step();
    set_req(1, 1'b0, 48'h5000, 28'd1, 16'h0014); step();
    s_valid = '0;
    step();
  endtask

  task automatic test_rights_irq();
    cfg_write(3, 1'b1, 2'b01, 48'h8000, 48'h8FFF);
    set_req(0, 1'b1, 48'h8000, 28'h10, 16'h0020); step();
    s_valid = '0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rights_irq_set: got %b expected 1", irq); end
    viol_clear = 1'b1; step(); viol_clear = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
    set_req(0, 1'b1, 48'h8010, 28'h10, 16'h0021);
    viol_clear = 1'b1; step(); viol_clear = 1'b0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear_vs_deny: got %b expected 1", irq); end
    set_req(0, 1'b0, 48'h8010, 28'h10, 16'h0022); step();
    s_valid = '0;
    set_req(1, 1'b0, 48'hFFFF_FFFF_FF00, 28'd4, 16'h0023);
    cfg_write(1, 1'b0, 2'b11, 48'hFFFF_FFFF_FF00, 48'hFFFF_FFFF_FFFF);
    n_checks++; if (m_valid[1] !== 1'b1) begin n_fail++; $display("FAIL cfg_old_table: got %b expected 1", m_valid[1]); end
    step();
    s_valid = '0;
    n_checks++; if (m_valid[1] !== 1'b0) begin n_fail++; $display("FAIL cfg_new_table: got %b expected 0", m_valid[1]); end
    viol_clear = 1'b1; step(); viol_clear = 1'b0;
    step();
  endtask

  task automatic test_log_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_req(0, 1'b0, 48'h100 + 48'(i), 28'(i + 1), 16'h0);
      step();
    end
    set_req(0, 1'b0, 48'h200, 28'h50, 16'h0);
    set_req(1, 1'b1, 48'h300, 28'h60, 16'h0);
    step();
    s_valid = '0;
    n_checks++; if (log_lost !== 32'd1) begin n_fail++; $display("FAIL lost_same_cycle: got %0d expected 1", log_lost); end
    set_req(1, 1'b0, 48'h400, 28'h70, 16'h0); step();
    s_valid = '0;
    n_checks++; if (log_lost !== 32'd2) begin n_fail++; $display("FAIL lost_full: got %0d expected 2", log_lost); end
    log_ready = 1'b1;
    set_req(0, 1'b1, 48'h500, 28'h80, 16'h0); step();
    s_valid = '0;
    log_ready = 1'b0;
    n_checks++;
    if (log_lost !== 32'd2 || viol_count !== 32'd11)
      begin n_fail++; $display("FAIL push_pop_full: got lost=%0d viol=%0d expected lost=2 viol=11", log_lost, viol_count); end
    step();
    log_ready = 1'b1;
    repeat (10) step();
    log_ready = 1'b0;
    n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL log_drain: got %b expected 0", log_valid); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] va1;
    logic [LW-1:0] ln1;
    int n0;
    do_reset();
    cfg_write(0, 1'b1, 2'b11, 48'h1000, 48'h1FFF);
    n0  = 0;
    va1 = 48'h1000 + 48'($urandom_range(0, 'hFFF));
    ln1 = 28'($urandom_range(1, 'h200));
    for (int i = 0; i < 30; i++) begin
      m_ready[1] = 1'($urandom_range(0, 1));
      set_req(0, 1'($urandom_range(0, 1)), 48'h1000 + 48'(i * 16), 28'(i + 1), 16'(i));
      set_req(1, 1'b1, va1, ln1, 16'h100 + 16'(i));
      step();
      if (acc[0]) n0++;
      if (acc[1]) begin
        va1 = 48'h1000 + 48'($urandom_range(0, 'hFFF));
        ln1 = 28'($urandom_range(1, 'h200));
      end
    end
    s_valid = '0;
    m_ready = 2'b11;
    n_checks++; if (n0 != 30) begin n_fail++; $display("FAIL ch0_throughput: got %0d expected 30", n0); end
    log_ready = 1'b1;
    repeat (12) step();
    log_ready = 1'b0;
  endtask

  task automatic test_stall_reset();
    m_ready[0] = 1'b0;
    set_req(0, 1'b0, 48'h1800, 28'd8, 16'h0077);
    step();
    set_req(0, 1'b0, 48'h1900, 28'd8, 16'h0078);
    repeat (5) step();
    n_checks++;
    if (s_ready[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_vaddr[47:0] !== 48'h1800)
      begin n_fail++; $display("FAIL stall_hold: got rdy=%b v=%b va=%h expected 0 1 1800", s_ready[0], m_valid[0], m_vaddr[47:0]); end
    areset  = 1'b1;
    s_valid = '0;
    @(posedge aclk);
    #1;
    n_checks++; if (m_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got %b expected 0", m_valid[0]); end
    do_reset();
    m_ready = 2'b11;
    step();
  endtask

  task automatic test_fail_stop();
    do_reset();
    cfg_write(0, 1'b1, 2'b11, 48'h1000, 48'h1FFF);
    set_req(0, 1'b0, 48'h1000, 28'd4, 16'h0200);
    set_req(1, 1'b0, 48'h0100, 28'd4, 16'h0201);
    step();
    n_checks++; if (fs_s_ready[1] !== 1'b0) begin n_fail++; $display("FAIL fs_halt_now: got %b expected 0", fs_s_ready[1]); end
    set_req(1, 1'b0, 48'h1100, 28'd4, 16'h0202);
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b0, 48'h1010 + 48'(i * 16), 28'd4, 16'h0210 + 16'(i));
      step();
      n_checks++;
      if (fs_s_ready !== 2'b01 || fs_m_valid !== 2'b01 || fs_m_tag[15:0] !== 16'h0210 + 16'(i))
        begin n_fail++; $display("FAIL fs_stream: got rdy=%b v=%b tag=%h cycle %0d", fs_s_ready, fs_m_valid, fs_m_tag[15:0], i); end
    end
    s_valid[0] = 1'b0;
    viol_clear = 1'b1;
    step();
    viol_clear = 1'b0;
    n_checks++; if (fs_s_ready[1] !== 1'b1) begin n_fail++; $display("FAIL fs_resume: got %b expected 1", fs_s_ready[1]); end
    step();
    s_valid = '0;
    n_checks++; if (fs_m_valid[1] !== 1'b1) begin n_fail++; $display("FAIL fs_after_clear: got %b expected 1", fs_m_valid[1]); end
    step();
  endtask

  initial begin
    areset     = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_valid  = 1'b0;
    cfg_rights = '0;
    cfg_base   = '0;
    cfg_bound  = '0;
    s_valid    = '0;
    s_dir      = '0;
    s_vaddr    = '0;
    s_len      = '0;
    s_tag      = '0;
    m_ready    = 2'b11;
    viol_clear = 1'b0;
    log_ready  = 1'b0;
    exp_rdy_en = 1'b0;
    acc        = '0;
    model_clear();

    test_reset();
    test_grant();
    test_wrap();
    test_rights_irq();
    test_log_overflow();
    test_back_to_back();
    test_stall_reset();
    test_fail_stop();

    s_valid   = '0;
    m_ready   = 2'b11;
    log_ready = 1'b1;
    repeat (12) step();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0 || lq.size() != 0)
      begin n_fail++; $display("FAIL leftovers: q0=%0d q1=%0d log=%0d expected all 0", q0.size(), q1.size(), lq.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
